// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host bridge: controller-matched widths,
// bridge FSM states and the request entry layout.
package sdram_pkg;

    localparam int SD_HADDR_WIDTH = 24;
    localparam int SD_DATA_WIDTH  = 16;
    localparam int SD_TAG_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bridge_state_e;

    // Canonical FIFO entry layout at the controller's widths.
    typedef struct packed {
        logic                      we;
        logic [SD_HADDR_WIDTH-1:0] addr;
        logic [SD_DATA_WIDTH-1:0]  wdata;
`ifdef SDRAM_BRIDGE_TAG_EN
        logic [SD_TAG_WIDTH-1:0]   tag;
`endif
    } req_entry_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count.
module sdram_req_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // full is evaluated before any same-cycle pop, so a full FIFO refuses
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sdram_host_bridge.sv
// Queues host read/write requests and issues them one at a time to the SDRAM
// controller's enable/busy interface. Optional tags: define SDRAM_BRIDGE_TAG_EN.
module sdram_host_bridge
    import sdram_pkg::*;
#(
    parameter int HADDR_WIDTH = SD_HADDR_WIDTH,
    parameter int DATA_WIDTH  = SD_DATA_WIDTH,
    parameter int DEPTH       = 4,
    parameter int TAG_WIDTH   = SD_TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
`ifdef SDRAM_BRIDGE_TAG_EN
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
`endif
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic [HADDR_WIDTH-1:0] sd_haddr,
    output logic [DATA_WIDTH-1:0]  sd_data_input,
    output logic                   sd_rd_enable,
    output logic                   sd_wr_enable,
    input  logic                   sd_busy,
    input  logic [DATA_WIDTH-1:0]  sd_data_output
);

`ifdef SDRAM_BRIDGE_TAG_EN
    localparam int TAG_BITS = TAG_WIDTH;
`else
    localparam int TAG_BITS = 0 * TAG_WIDTH;
`endif
    localparam int ENTRY_W = 1 + HADDR_WIDTH + DATA_WIDTH + TAG_BITS;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;
    logic                   head_we;
    logic [HADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]  head_wdata;
    logic                   cmd_we;
    bridge_state_e          state_q;
    bridge_state_e          state_d;

`ifdef SDRAM_BRIDGE_TAG_EN
    logic [TAG_WIDTH-1:0]   head_tag;
    logic [TAG_WIDTH-1:0]   cmd_tag;
    assign push_entry = {req_we, req_addr, req_wdata, req_tag};
    assign {head_we, head_addr, head_wdata, head_tag} = head_entry;
`else
    assign push_entry = {req_we, req_addr, req_wdata};
    assign {head_we, head_addr, head_wdata} = head_entry;
`endif

    assign req_ready = !fifo_full;

    sdram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            // enable is held across init/refresh stalls until busy is seen
            ISSUE:   if (sd_busy)  state_d = WAIT;
            WAIT:    if (!sd_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sd_haddr      <= '0;
            sd_data_input <= '0;
            sd_rd_enable  <= 1'b0;
            sd_wr_enable  <= 1'b0;
            cmd_we        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
`ifdef SDRAM_BRIDGE_TAG_EN
            cmd_tag       <= '0;
            rsp_tag       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rsp_valid <= 1'b0;
            if (fifo_pop) begin
                sd_haddr      <= head_addr;
                sd_data_input <= head_wdata;
                cmd_we        <= head_we;
                sd_rd_enable  <= !head_we;
                sd_wr_enable  <= head_we;
`ifdef SDRAM_BRIDGE_TAG_EN
                cmd_tag       <= head_tag;
`endif
            end
            if (state_q == ISSUE && sd_busy) begin
                sd_rd_enable <= 1'b0;
                sd_wr_enable <= 1'b0;
            end
            if (state_q == WAIT && !sd_busy && !cmd_we) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= sd_data_output;
`ifdef SDRAM_BRIDGE_TAG_EN
                rsp_tag   <= cmd_tag;
`endif
            end
        end
    end

endmodule
